toggle_pulse_gen: RTL and testbench
===================================

Name: toggle_pulse_gen

Overview:
Upstream conditioning stage for the toggle flip-flop. It synchronises and debounces a raw push-button, then emits single-cycle toggle pulses on t_out to drive the flip-flop's t input. Optional auto-repeat issues further pulses while the button stays held. It also provides a debounced level and a pulse counter for observation.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal samples of the synchronised button required to accept a press or a release (minimum 2).
REPEAT_DELAY, 16, cycles from the first pulse of a hold to the first repeat pulse.
REPEAT_PERIOD, 8, cycles between later repeat pulses; 0 disables auto-repeat.
CNT_W, 8, width of the debounce/repeat counters and of pulse_cnt.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-low.
btn_in  input  1  raw button, asynchronous to clk, active-high.
en  input  1  pulse enable; 0 suppresses t_out and pulse_cnt updates.
t_out  output  1  one-cycle toggle pulse; connects to the flip-flop t input.
btn_level  output  1  debounced button level.
pulse_cnt  output  CNT_W  count of pulses emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0 at a rising edge):
  - Synchroniser flops, FSM, counters and all outputs clear: t_out=0, btn_level=0, pulse_cnt=0, state=IDLE.
  - Reset has priority over all other inputs, including mid-debounce and mid-hold.
- Synchroniser: 2-flop chain btn_in -> s1 -> btn_s. The FSM sees only btn_s. Edge numbering: edge 1 is the first rising edge that samples btn_in=1; btn_s=1 after edge 2.
- All outputs are registered.
- FSM states:
  - IDLE (btn_level=0): btn_s=1 -> PRESS_CHK with deb_cnt=1.
  - PRESS_CHK:
    - btn_s=0 -> IDLE (bounce rejected; no pulse, no counter change).
    - btn_s=1 and deb_cnt=DEBOUNCE_CYCLES-1 -> HELD. On that edge: btn_level<=1, t_out<=en, rep_cnt<=0.
    - Otherwise deb_cnt++.
  - HELD (btn_level=1): rep_cnt increments each cycle.
    - btn_s=0 -> REL_CHK with deb_cnt=1.
    - If REPEAT_PERIOD!=0, a repeat pulse (t_out<=en) fires when rep_cnt reaches REPEAT_DELAY-1 after the first pulse. Later pulses fire every REPEAT_PERIOD cycles after that.
  - REL_CHK (btn_level stays 1):
    - btn_s=1 -> HELD with rep_cnt<=0 (repeat timing restarts; no pulse).
    - DEBOUNCE_CYCLES consecutive btn_s=0 samples -> IDLE with btn_level<=0.
    - No pulses are issued in REL_CHK.
- Timing:
  - Accepted press: t_out and btn_level rise at edge DEBOUNCE_CYCLES+2 (edge 6 for the defaults).
  - Release: btn_level falls at edge DEBOUNCE_CYCLES+2, counted from the first edge sampling btn_in=0.
- t_out is never high for 2 consecutive cycles. Each pulse increments pulse_cnt on the same edge that sets t_out. 2^CNT_W-1 wraps to 0.
- en=0:
  - FSM and btn_level still track the button.
  - Pulses due in this state are dropped, not queued, and pulse_cnt holds.
  - en changing mid-hold affects only subsequent pulses.
- Counters saturate-safe: deb_cnt and rep_cnt are cleared on every state change and never wrap within a state.
- Button held across reset release: treated as a new press. Edge numbering restarts at the first edge with rst=1, so a pulse appears at edge DEBOUNCE_CYCLES+2 after release.
- btn_in changing at the same edge as a state transition: the registered btn_s value decides. There is no combinational path from btn_in to any output.

Test Plan:
1. rst=0 for 2 cycles with btn_in=1, en=1 -> t_out=0, btn_level=0, pulse_cnt=0 throughout reset.
2. Clean press, btn_in=1 for 10 cycles then 0 (defaults) -> exactly one t_out pulse at edge 6; btn_level high from edge 6 until 6 edges after release; pulse_cnt=1.
3. Bounce:
   - btn_in=1 for 3 cycles then 0 -> no pulse, btn_level stays 0.
   - Then a valid press with btn_in held low for 2 cycles mid-hold -> btn_level stays 1, still only 1 pulse in total.
4. Auto-repeat, btn_in held 40 cycles -> pulses at edges 6, 22, 30, 38; pulse_cnt=4; no pulse after release begins.
5. en=0 with the scenario-2 stimulus -> btn_level behaves as in scenario 2; t_out never asserts; pulse_cnt unchanged.
6. Reset mid-hold at edge 20 for 1 cycle, btn_in kept 1 -> all outputs cleared at edge 20; a new pulse 6 edges after rst returns high; pulse_cnt=1 after that pulse.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
// Push-button conditioning for a toggle flip-flop: 2-flop synchroniser, press/release
// debounce, single-cycle toggle pulses with optional auto-repeat, and a pulse counter.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             en,
  output logic             t_out,
  output logic             btn_level,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             s1_reg, btn_s_reg;
  logic [CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_phase_reg, rep_phase_next;
  logic             t_out_reg, t_out_next;
  logic             btn_level_reg, btn_level_next;
  logic [CNT_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic             fire;
  logic             rep_due;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg        <= 1'b0;
      btn_s_reg     <= 1'b0;
      state_reg     <= IDLE;
      deb_cnt_reg   <= '0;
      rep_cnt_reg   <= '0;
      rep_phase_reg <= 1'b0;
      t_out_reg     <= 1'b0;
      btn_level_reg <= 1'b0;
      pulse_cnt_reg <= '0;
    end else begin
      s1_reg        <= btn_in;
      btn_s_reg     <= s1_reg;
      state_reg     <= state_next;
      deb_cnt_reg   <= deb_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      rep_phase_reg <= rep_phase_next;
      t_out_reg     <= t_out_next;
      btn_level_reg <= btn_level_next;
      pulse_cnt_reg <= pulse_cnt_next;
    end
  end

  // First repeat waits REPEAT_DELAY from the hold start; later ones use REPEAT_PERIOD.
  // The >= keeps a blocked repeat (pulse already high) from being lost forever.
  always_comb begin
    rep_due = 1'b0;
    if (REPEAT_PERIOD != 0) begin
      if (rep_phase_reg) rep_due = (rep_cnt_reg >= PER_LAST);
      else               rep_due = (rep_cnt_reg >= DELAY_LAST);
    end
  end

  always_comb begin
    state_next     = state_reg;
    deb_cnt_next   = deb_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_phase_next = rep_phase_reg;
    btn_level_next = btn_level_reg;
    fire           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (btn_s_reg) begin
          state_next   = PRESS_CHK;
          deb_cnt_next = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!btn_s_reg) begin
          state_next   = IDLE;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next     = HELD;
          deb_cnt_next   = '0;
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
          btn_level_next = 1'b1;
          fire           = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s_reg) begin
          state_next     = REL_CHK;
          deb_cnt_next   = CNT_ONE;
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
        end else if (rep_due && !t_out_reg) begin
          fire           = 1'b1;
          rep_cnt_next   = '0;
          rep_phase_next = 1'b1;
        end else if (rep_cnt_reg != CNT_MAX) begin
          rep_cnt_next = rep_cnt_reg + CNT_ONE;
        end
      end
      REL_CHK: begin
        if (btn_s_reg) begin
          state_next     = HELD;
          deb_cnt_next   = '0;
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next     = IDLE;
          deb_cnt_next   = '0;
          btn_level_next = 1'b0;
        end else begin
          deb_cnt_next = deb_cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next     = IDLE;
        deb_cnt_next   = '0;
        rep_cnt_next   = '0;
        rep_phase_next = 1'b0;
        btn_level_next = 1'b0;
      end
    endcase

    // Pulses due while disabled are dropped rather than queued.
    t_out_next     = fire & en;
    pulse_cnt_next = (fire & en) ? pulse_cnt_reg + CNT_ONE : pulse_cnt_reg;
  end

  assign t_out     = t_out_reg;
  assign btn_level = btn_level_reg;
  assign pulse_cnt = pulse_cnt_reg;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: directed vector table, hand-written corner sequences and
// randomized button/enable/reset traffic checked every cycle against a behavioural model.
module tb_toggle_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_in = 1'b0;
  logic          en = 1'b0;
  logic          t_out;
  logic          btn_level;
  logic [CW-1:0] pulse_cnt;

  int checks = 0;
  int errors = 0;

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .en       (en),
    .t_out    (t_out),
    .btn_level(btn_level),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: the debounced level flips once DEB consecutive synchronised
  // samples disagree with it; repeats fire at fixed offsets from the latest hold start.
  bit m_d1, m_d2, m_level, m_t;
  int m_run, m_anchor, m_cnt, n_edge;

  task automatic model_step(input bit r, input bit b, input bit e);
    bit seen, pulse, was_held, was_rel;
    int age;
    n_edge++;
    if (!r) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_t = 0; m_cnt = 0; m_anchor = 0;
      return;
    end
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = b;
    pulse = 0;
    was_held = m_level && (m_run == 0);
    was_rel  = m_level && (m_run > 0);
    if (seen != m_level) m_run++;
    else m_run = 0;
    if (was_held && seen) begin
      age = n_edge - m_anchor;
      if (RP != 0 && (age == RD || (age > RD && (age - RD) % RP == 0))) pulse = 1;
    end
    if (was_rel && seen) m_anchor = n_edge;
    if (m_run == DEB) begin
      m_level = !m_level;
      m_run = 0;
      if (m_level) begin
        pulse = 1;
        m_anchor = n_edge;
      end
    end
    m_t = pulse && e;
    if (m_t) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Per-sequence trackers, edge numbers relative to the last clear_trk.
  int   seq_edge, seq_pulses, seq_rise, seq_fall, seq_falls, seq_first, seq_last;
  logic prev_lvl;

  task automatic clear_trk();
    seq_edge = 0; seq_pulses = 0; seq_rise = 0; seq_fall = 0;
    seq_falls = 0; seq_first = 0; seq_last = 0;
    prev_lvl = btn_level;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(rst, btn_in, en);
    seq_edge++;
    $display("edge %0d rst=%0b btn=%0b en=%0b -> t_out=%0b level=%0b cnt=%0d", seq_edge,
             rst, btn_in, en, t_out, btn_level, pulse_cnt);
    check("model_t_out", 32'(t_out), 32'(m_t));
    check("model_btn_level", 32'(btn_level), 32'(m_level));
    check("model_pulse_cnt", 32'(pulse_cnt), 32'(m_cnt));
    if (t_out === 1'b1) begin
      seq_pulses++;
      if (seq_first == 0) seq_first = seq_edge;
      seq_last = seq_edge;
    end
    if (btn_level === 1'b1 && prev_lvl !== 1'b1 && seq_rise == 0) seq_rise = seq_edge;
    if (btn_level === 1'b0 && prev_lvl === 1'b1) begin
      seq_fall = seq_edge;
      seq_falls++;
    end
    prev_lvl = btn_level;
  endtask

  task automatic drive(input bit b, input int n);
    btn_in = b;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int hold;
    bit en;
    int pulses;
    int rise;
    int fall;
    int first;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int start_cnt, len;
    logic [CW-1:0] base;

    vecs[0] = '{10, 1'b1, 1, 6, 16, 6};
    vecs[1] = '{3,  1'b1, 0, 0, 0,  0};
    vecs[2] = '{4,  1'b1, 1, 6, 10, 6};
    vecs[3] = '{40, 1'b1, 4, 6, 46, 6};
    vecs[4] = '{10, 1'b0, 0, 6, 16, 0};
    vecs[5] = '{20, 1'b1, 2, 6, 26, 6};
    vecs[6] = '{19, 1'b1, 1, 6, 25, 6};

    // Reset with button pressed and enable high.
    rst = 1'b0; btn_in = 1'b1; en = 1'b1;
    clear_trk();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_t_out", 32'(t_out), 0);
      check("reset_btn_level", 32'(btn_level), 0);
      check("reset_pulse_cnt", 32'(pulse_cnt), 0);
    end
    rst = 1'b1;
    drive(1'b0, 10);

    // Table-driven presses.
    for (int v = 0; v < 7; v++) begin
      en = vecs[v].en;
      clear_trk();
      base = pulse_cnt;
      drive(1'b1, vecs[v].hold);
      drive(1'b0, 25);
      check($sformatf("vec%0d_pulses", v), 32'(seq_pulses), 32'(vecs[v].pulses));
      check($sformatf("vec%0d_rise_edge", v), 32'(seq_rise), 32'(vecs[v].rise));
      check($sformatf("vec%0d_fall_edge", v), 32'(seq_fall), 32'(vecs[v].fall));
      check($sformatf("vec%0d_first_pulse", v), 32'(seq_first), 32'(vecs[v].first));
      check($sformatf("vec%0d_cnt_delta", v), 32'(CW'(pulse_cnt - base)),
            32'(vecs[v].pulses));
    end

    // Two-cycle dropout mid-hold: level holds and the repeat timer restarts.
    en = 1'b1;
    clear_trk();
    base = pulse_cnt;
    drive(1'b1, 12);
    drive(1'b0, 2);
    drive(1'b1, 10);
    drive(1'b0, 25);
    check("dropout_pulses", 32'(seq_pulses), 1);
    check("dropout_falls", 32'(seq_falls), 1);
    check("dropout_cnt_delta", 32'(CW'(pulse_cnt - base)), 1);

    // Reset for one cycle at edge 20 of a hold; the press restarts after release.
    clear_trk();
    btn_in = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      rst = (e == 20) ? 1'b0 : 1'b1;
      tick();
      if (e == 20) begin
        check("midrst_t_out", 32'(t_out), 0);
        check("midrst_btn_level", 32'(btn_level), 0);
        check("midrst_pulse_cnt", 32'(pulse_cnt), 0);
      end
    end
    rst = 1'b1;
    drive(1'b0, 25);
    check("midrst_pulses", 32'(seq_pulses), 2);
    check("midrst_second_pulse", 32'(seq_last), 26);
    check("midrst_final_cnt", 32'(pulse_cnt), 1);

    // Randomized traffic, including short bounces and rare one-cycle resets.
    for (int seg = 0; seg < 150; seg++) begin
      btn_in = ~btn_in;
      en = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 50);
      for (int i = 0; i < len; i++) begin
        rst = ($urandom_range(0, 199) != 0);
        tick();
      end
      rst = 1'b1;
    end

    // Long hold so pulse_cnt wraps past its maximum.
    en = 1'b1;
    drive(1'b0, 10);
    start_cnt = m_cnt;
    clear_trk();
    drive(1'b1, 2200);
    drive(1'b0, 12);
    check("wrap_pulses", 32'(seq_pulses), 32'(1 + (2200 - 2 - RD) / RP + 1));
    check("wrap_cnt", 32'(pulse_cnt), 32'((start_cnt + seq_pulses) % (1 << CW)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
